// File: rtl/binary_game_engine.sv
// binary_game_engine: menu-driven binary-conversion game controller.
// Draws pseudo-random targets from a 16-bit Galois LFSR, scores timed play
// rounds, keeps a high score and offers an untimed practice mode.
//
// Ports:
//   Clk, Reset           clock (rising edge), async active-low reset
//   Select, Quit         confirm / abort pulses (debounced upstream)
//   selectRight/Left     menu navigation pulses
//   userNumber           player's answer switches
//   outputNumber         current target, or the high score while in SCORES
//   q_State              one-hot state (INITIAL = bit 0 ... DONE = bit 12)
//   score, highScore     current score, best completed-game score
//   roundNum, timeLeft   current round (1-based), cycles left in the round
//   correct, wrong       one-cycle verdict pulses
//   hintMask             practice hint (userNumber ^ target)
//
// Optional feature: define BINARY_GAME_HINT_EN to build the practice hint
// register; without it hintMask is tied to zero.
module binary_game_engine #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ROUNDS     = 10,
  parameter int unsigned TIME_LIMIT = 250000000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Select,
  input  logic             Quit,
  input  logic             selectRight,
  input  logic             selectLeft,
  input  logic [WIDTH-1:0] userNumber,
  output logic [WIDTH-1:0] outputNumber,
  output logic [12:0]      q_State,
  output logic [7:0]       score,
  output logic [7:0]       highScore,
  output logic [7:0]       roundNum,
  output logic [31:0]      timeLeft,
  output logic             correct,
  output logic             wrong,
  output logic [WIDTH-1:0] hintMask
);

  localparam int unsigned NUM_STATES  = 13;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [31:0] TIME_RELOAD = 32'(TIME_LIMIT - 1);
  localparam logic [7:0]  LAST_ROUND  = 8'(ROUNDS);

  typedef enum logic [3:0] {
    INITIAL       = 4'd0,
    MENU_PLAY     = 4'd1,
    MENU_PRACTICE = 4'd2,
    MENU_SCORES   = 4'd3,
    MENU_QUIT     = 4'd4,
    PLAY_INIT     = 4'd5,
    PLAY          = 4'd6,
    PLAY_DONE     = 4'd7,
    PRACTICE_INIT = 4'd8,
    PRACTICE      = 4'd9,
    PRACTICE_DONE = 4'd10,
    SCORES        = 4'd11,
    DONE          = 4'd12
  } stateT;

  stateT            state, stateNext;
  logic [15:0]      lfsr, lfsrNext;
  logic [WIDTH-1:0] target, targetNext;
  logic [WIDTH-1:0] outputNext;
  logic [12:0]      oneHotNext;
  logic [7:0]       scoreNext, highScoreNext, roundNext;
  logic [31:0]      timeNext;
  logic             correctNext, wrongNext;
  logic             navRight, navLeft, isHit, verdict;

  // Pressing both directions at once is a hold
  assign navRight = selectRight & ~selectLeft;
  assign navLeft  = selectLeft & ~selectRight;
  assign isHit    = (userNumber == target);

  // Free-running LFSR step
  assign lfsrNext = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

  // State register and all registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= INITIAL;
      q_State      <= NUM_STATES'(1);
      lfsr         <= LFSR_SEED;
      target       <= '0;
      outputNumber <= '0;
      score        <= '0;
      highScore    <= '0;
      roundNum     <= '0;
      timeLeft     <= '0;
      correct      <= 1'b0;
      wrong        <= 1'b0;
    end else begin
      state        <= stateNext;
      q_State      <= oneHotNext;
      lfsr         <= lfsrNext;
      target       <= targetNext;
      outputNumber <= outputNext;
      score        <= scoreNext;
      highScore    <= highScoreNext;
      roundNum     <= roundNext;
      timeLeft     <= timeNext;
      correct      <= correctNext;
      wrong        <= wrongNext;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stateNext     = state;
    targetNext    = target;
    scoreNext     = score;
    highScoreNext = highScore;
    roundNext     = roundNum;
    timeNext      = timeLeft;
    correctNext   = 1'b0;
    wrongNext     = 1'b0;
    verdict       = 1'b0;

    case (state)
      INITIAL: if (Select) stateNext = MENU_PLAY;

      MENU_PLAY: begin
        if (Select)        stateNext = PLAY_INIT;
        else if (navRight) stateNext = MENU_PRACTICE;
        else if (navLeft)  stateNext = MENU_QUIT;
      end

      MENU_PRACTICE: begin
        if (Select)        stateNext = PRACTICE_INIT;
        else if (navRight) stateNext = MENU_SCORES;
        else if (navLeft)  stateNext = MENU_PLAY;
      end

      MENU_SCORES: begin
        if (Select)        stateNext = SCORES;
        else if (navRight) stateNext = MENU_QUIT;
        else if (navLeft)  stateNext = MENU_PRACTICE;
      end

      MENU_QUIT: begin
        if (Select)        stateNext = DONE;
        else if (navRight) stateNext = MENU_PLAY;
        else if (navLeft)  stateNext = MENU_SCORES;
      end

      PLAY_INIT: begin
        scoreNext  = '0;
        roundNext  = 8'd1;
        targetNext = WIDTH'(lfsr);
        timeNext   = TIME_RELOAD;
        stateNext  = PLAY;
      end

      PLAY: begin
        if (Quit) begin
          // Abandoned game: score is dropped, high score untouched
          scoreNext = '0;
          stateNext = MENU_PLAY;
        end else begin
          timeNext = timeLeft - 32'd1;
          // An answer in the last cycle is judged rather than timed out
          if (Select) begin
            verdict = 1'b1;
            if (isHit) begin
              correctNext = 1'b1;
              if (score != 8'hFF) scoreNext = score + 8'd1;
            end else begin
              wrongNext = 1'b1;
            end
          end else if (timeLeft == 32'd0) begin
            verdict   = 1'b1;
            wrongNext = 1'b1;
          end

          if (verdict) begin
            if (roundNum == LAST_ROUND) begin
              stateNext     = PLAY_DONE;
              timeNext      = '0;
              highScoreNext = (scoreNext > highScore) ? scoreNext : highScore;
            end else begin
              roundNext  = roundNum + 8'd1;
              targetNext = WIDTH'(lfsr);
              timeNext   = TIME_RELOAD;
            end
          end
        end
      end

      PLAY_DONE: if (Select || Quit) stateNext = MENU_PLAY;

      PRACTICE_INIT: begin
        targetNext = WIDTH'(lfsr);
        stateNext  = PRACTICE;
      end

      PRACTICE: begin
        if (Quit) begin
          stateNext = PRACTICE_DONE;
        end else if (Select) begin
          if (isHit) begin
            correctNext = 1'b1;
            targetNext  = WIDTH'(lfsr);
          end else begin
            wrongNext = 1'b1;
          end
        end
      end

      PRACTICE_DONE: if (Select || Quit) stateNext = MENU_PRACTICE;

      SCORES: if (Select || Quit) stateNext = MENU_SCORES;

      DONE: stateNext = DONE;

      default: stateNext = INITIAL;
    endcase

    oneHotNext = NUM_STATES'(1) << stateNext;
    outputNext = (stateNext == SCORES) ? WIDTH'(highScore) : targetNext;
  end

`ifdef BINARY_GAME_HINT_EN
  // Practice hint: bits still differing between answer and target
  logic [WIDTH-1:0] hintNext;
  assign hintNext = (stateNext == PRACTICE) ? (userNumber ^ targetNext) : '0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) hintMask <= '0;
    else        hintMask <= hintNext;
  end
`else
  assign hintMask = '0;
`endif

endmodule

// File: tb/tb_binary_game_engine.sv
// Scoreboard bench for binary_game_engine (WIDTH=4, ROUNDS=3, TIME_LIMIT=8).
// Stimulus pushes expected verdicts; a negedge monitor pops and compares
// whenever correct or wrong pulses.
module tb_binary_game_engine;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned ROUNDS     = 3;
  localparam int unsigned TIME_LIMIT = 8;

  localparam logic [12:0] S_INITIAL       = 13'h0001;
  localparam logic [12:0] S_MENU_PLAY     = 13'h0002;
  localparam logic [12:0] S_MENU_PRACTICE = 13'h0004;
  localparam logic [12:0] S_MENU_SCORES   = 13'h0008;
  localparam logic [12:0] S_MENU_QUIT     = 13'h0010;
  localparam logic [12:0] S_PLAY_INIT     = 13'h0020;
  localparam logic [12:0] S_PLAY          = 13'h0040;
  localparam logic [12:0] S_PLAY_DONE     = 13'h0080;
  localparam logic [12:0] S_PRACTICE_INIT = 13'h0100;
  localparam logic [12:0] S_PRACTICE      = 13'h0200;
  localparam logic [12:0] S_PRACTICE_DONE = 13'h0400;
  localparam logic [12:0] S_SCORES        = 13'h0800;
  localparam logic [12:0] S_DONE          = 13'h1000;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Select = 1'b0;
  logic             Quit = 1'b0;
  logic             selectRight = 1'b0;
  logic             selectLeft = 1'b0;
  logic [WIDTH-1:0] userNumber = '0;
  logic [WIDTH-1:0] outputNumber;
  logic [12:0]      q_State;
  logic [7:0]       score, highScore, roundNum;
  logic [31:0]      timeLeft;
  logic             correct, wrong;
  logic [WIDTH-1:0] hintMask;

  binary_game_engine #(
    .WIDTH(WIDTH), .ROUNDS(ROUNDS), .TIME_LIMIT(TIME_LIMIT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Select(Select), .Quit(Quit),
    .selectRight(selectRight), .selectLeft(selectLeft),
    .userNumber(userNumber), .outputNumber(outputNumber), .q_State(q_State),
    .score(score), .highScore(highScore), .roundNum(roundNum),
    .timeLeft(timeLeft), .correct(correct), .wrong(wrong), .hintMask(hintMask)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, one step per edge
  logic [15:0] refLfsr;
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) refLfsr <= 16'hACE1;
    else        refLfsr <= {1'b0, refLfsr[15:1]} ^ (refLfsr[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct {
    logic       isCorrect;
    logic [3:0] target;
    logic       chkRound;
    logic [7:0] round;
    logic [7:0] score;
  } verdictT;

  verdictT sb[$];
  verdictT got;
  int nCompared = 0;
  int nMismatch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expectVerdict(input logic isC, input logic [3:0] tgt,
                               input logic chk, input logic [7:0] rnd, input logic [7:0] scr);
    verdictT v;
    v.isCorrect = isC; v.target = tgt; v.chkRound = chk; v.round = rnd; v.score = scr;
    sb.push_back(v);
  endtask

  // Called at a negedge; inputs are seen by exactly one rising edge
  task automatic step(input logic sel, input logic qt, input logic r, input logic l);
    Select = sel; Quit = qt; selectRight = r; selectLeft = l;
    @(negedge Clk);
    Select = 1'b0; Quit = 1'b0; selectRight = 1'b0; selectLeft = 1'b0;
  endtask

  task automatic checkAllClear(input string tag);
    check({tag, "_state"},  32'(q_State), 32'(S_INITIAL));
    check({tag, "_out"},    32'(outputNumber), 32'd0);
    check({tag, "_score"},  32'(score), 32'd0);
    check({tag, "_high"},   32'(highScore), 32'd0);
    check({tag, "_round"},  32'(roundNum), 32'd0);
    check({tag, "_time"},   timeLeft, 32'd0);
    check({tag, "_pulses"}, 32'({correct, wrong}), 32'd0);
    check({tag, "_hint"},   32'(hintMask), 32'd0);
  endtask

  // Monitor: every verdict pulse must match the oldest expectation
  always @(negedge Clk) begin
    if (Reset && (correct || wrong)) begin
      if (sb.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("FAIL unexpected_verdict: got correct=%0b wrong=%0b expected none (t=%0t)",
                 correct, wrong, $time);
      end else begin
        got = sb.pop_front();
        check("verdict_correct", 32'(correct), 32'(got.isCorrect));
        check("verdict_wrong", 32'(wrong), 32'(!got.isCorrect));
        check("verdict_target", 32'(outputNumber), 32'(got.target));
        if (got.chkRound) begin
          check("verdict_round", 32'(roundNum), 32'(got.round));
          check("verdict_score", 32'(score), 32'(got.score));
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] curT;
  logic [3:0] nextT;
  int cnt;

  initial begin
    // Reset to menu
    repeat (2) @(negedge Clk);
    checkAllClear("reset");
    Reset = 1'b1;
    @(negedge Clk);
    check("idle_initial", 32'(q_State), 32'(S_INITIAL));
    step(1, 0, 0, 0);
    check("menu_play", 32'(q_State), 32'(S_MENU_PLAY));
    check("menu_out", 32'(outputNumber), 32'd0);
    check("menu_score_round", 32'({score, roundNum}), 32'd0);
    check("menu_time", timeLeft, 32'd0);

    // Menu ring
    step(0, 0, 0, 1); check("ring_left_quit",  32'(q_State), 32'(S_MENU_QUIT));
    step(0, 0, 1, 0); check("ring_right_play", 32'(q_State), 32'(S_MENU_PLAY));
    step(0, 0, 1, 1); check("ring_both_hold",  32'(q_State), 32'(S_MENU_PLAY));
    step(0, 0, 1, 0); check("ring_practice",   32'(q_State), 32'(S_MENU_PRACTICE));
    step(0, 0, 1, 0); check("ring_scores",     32'(q_State), 32'(S_MENU_SCORES));
    step(0, 0, 0, 1); check("ring_back_prac",  32'(q_State), 32'(S_MENU_PRACTICE));
    step(0, 0, 0, 1); check("ring_back_play",  32'(q_State), 32'(S_MENU_PLAY));

    // Full game: correct, wrong, timeout
    step(1, 0, 0, 0);
    check("play_init", 32'(q_State), 32'(S_PLAY_INIT));
    curT = refLfsr[3:0];
    step(0, 0, 0, 0);
    check("play_enter", 32'(q_State), 32'(S_PLAY));
    check("play_target", 32'(outputNumber), 32'(curT));
    check("play_round1", 32'(roundNum), 32'd1);
    check("play_time_init", timeLeft, 32'd7);
    userNumber = curT;
    nextT = refLfsr[3:0];
    expectVerdict(1, nextT, 1, 8'd2, 8'd1);
    step(1, 0, 0, 0);
    curT = nextT;
    check("play_time_reload", timeLeft, 32'd7);
    userNumber = curT ^ 4'h1;
    nextT = refLfsr[3:0];
    expectVerdict(0, nextT, 1, 8'd3, 8'd1);
    step(1, 0, 0, 0);
    curT = nextT;
    expectVerdict(0, curT, 1, 8'd3, 8'd1);
    cnt = 0;
    while (q_State == S_PLAY && cnt < 20) begin
      cnt++;
      @(negedge Clk);
    end
    check("timeout_cycles", 32'(cnt), 32'd8);
    check("game_done", 32'(q_State), 32'(S_PLAY_DONE));
    check("game_score", 32'(score), 32'd1);
    check("game_high", 32'(highScore), 32'd1);
    step(1, 0, 0, 0);
    check("done_to_menu", 32'(q_State), 32'(S_MENU_PLAY));

    // Quit mid-game after two correct answers
    step(1, 0, 0, 0);
    curT = refLfsr[3:0];
    step(0, 0, 0, 0);
    userNumber = curT;
    nextT = refLfsr[3:0];
    expectVerdict(1, nextT, 1, 8'd2, 8'd1);
    step(1, 0, 0, 0);
    curT = nextT;
    userNumber = curT;
    nextT = refLfsr[3:0];
    expectVerdict(1, nextT, 1, 8'd3, 8'd2);
    step(1, 0, 0, 0);
    curT = nextT;
    step(0, 1, 0, 0);
    check("quit_menu", 32'(q_State), 32'(S_MENU_PLAY));
    check("quit_high", 32'(highScore), 32'd1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    check("scores_state", 32'(q_State), 32'(S_SCORES));
    check("scores_out", 32'(outputNumber), 32'd1);
    step(0, 1, 0, 0);
    check("scores_back", 32'(q_State), 32'(S_MENU_SCORES));
    step(0, 0, 0, 1);
    check("to_menu_practice", 32'(q_State), 32'(S_MENU_PRACTICE));

    // Practice
    step(1, 0, 0, 0);
    check("prac_init", 32'(q_State), 32'(S_PRACTICE_INIT));
    curT = refLfsr[3:0];
    step(0, 0, 0, 0);
    check("prac_enter", 32'(q_State), 32'(S_PRACTICE));
    check("prac_target", 32'(outputNumber), 32'(curT));
    userNumber = curT ^ 4'b0101;
    expectVerdict(0, curT, 0, 8'd0, 8'd0);
    step(1, 0, 0, 0);
    check("prac_stay", 32'(q_State), 32'(S_PRACTICE));
`ifdef BINARY_GAME_HINT_EN
    check("prac_hint", 32'(hintMask), 32'h5);
`else
    check("prac_hint", 32'(hintMask), 32'h0);
`endif
    userNumber = curT;
    nextT = refLfsr[3:0];
    expectVerdict(1, nextT, 0, 8'd0, 8'd0);
    step(1, 0, 0, 0);
    curT = nextT;
    step(0, 1, 0, 0);
    check("prac_done", 32'(q_State), 32'(S_PRACTICE_DONE));
    check("prac_done_hint", 32'(hintMask), 32'h0);
    step(1, 0, 0, 0);
    check("prac_back", 32'(q_State), 32'(S_MENU_PRACTICE));

    // Select+Quit together in PLAY: quit wins, no verdict
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    curT = refLfsr[3:0];
    step(0, 0, 0, 0);
    userNumber = curT;
    step(1, 1, 0, 0);
    check("selquit_menu", 32'(q_State), 32'(S_MENU_PLAY));
    check("selquit_pulses", 32'({correct, wrong}), 32'd0);

    // Correct answer in the timeLeft==0 cycle
    step(1, 0, 0, 0);
    curT = refLfsr[3:0];
    step(0, 0, 0, 0);
    cnt = 0;
    while (timeLeft != 32'd0 && cnt < 20) begin
      cnt++;
      step(0, 0, 0, 0);
    end
    check("edge_time_zero", timeLeft, 32'd0);
    check("edge_idle_cycles", 32'(cnt), 32'd7);
    userNumber = curT;
    nextT = refLfsr[3:0];
    expectVerdict(1, nextT, 1, 8'd2, 8'd1);
    step(1, 0, 0, 0);
    check("edge_still_play", 32'(q_State), 32'(S_PLAY));

    // Asynchronous reset mid-round
    step(0, 0, 0, 0);
    Reset = 1'b0;
    #1;
    checkAllClear("midreset");
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    step(1, 0, 0, 0);
    check("post_reset_menu", 32'(q_State), 32'(S_MENU_PLAY));
    check("post_reset_high", 32'(highScore), 32'd0);

    // DONE is absorbing
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    check("done_enter", 32'(q_State), 32'(S_DONE));
    step(1, 0, 0, 0); check("done_hold_sel",  32'(q_State), 32'(S_DONE));
    step(0, 1, 0, 0); check("done_hold_quit", 32'(q_State), 32'(S_DONE));
    step(0, 0, 1, 0); check("done_hold_right", 32'(q_State), 32'(S_DONE));
    step(1, 1, 1, 1); check("done_hold_all",  32'(q_State), 32'(S_DONE));

    repeat (2) @(negedge Clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
